i2s_rx_stream: RTL and testbench
================================

I2S_RX_STREAM -- requirements
Module: i2s_rx_stream

Interface
REQ-001 Parameter DEPTH, default 4: FIFO depth in 32-bit frames; power of 2, minimum 2.
REQ-002 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i2s_bclk  input  1  I2S bit clock; asynchronous to clk; period at least 8 clk periods.
REQ-005 i2s_lrclk  input  1  I2S word select; 0 = left, 1 = right.
REQ-006 i2s_sdata  input  1  I2S serial data, MSB first.
REQ-007 aud_out  output  32  head-of-FIFO frame, {left[15:0], right[15:0]}.
REQ-008 aud_out_rts  output  1  ready-to-send: FIFO not empty.
REQ-009 aud_out_rtr  input  1  ready-to-receive from the downstream consumer.
REQ-010 fifo_level  output  $clog2(DEPTH)+1  number of frames held.
REQ-011 overflow  output  1  one-cycle pulse: complete frame dropped because FIFO full.
REQ-012 frame_err  output  1  one-cycle pulse: frame dropped because a channel was shorter than 16 bits.

Function
REQ-013 i2s_bclk, i2s_lrclk and i2s_sdata shall each pass through a 2-flop synchronizer before use.
REQ-014 A bclk rise is detected in the clk cycle where synchronized bclk = 1 and its previous sample = 0.
REQ-015 On each detected rise, register lr_d <= lrclk and lr_dd <= lr_d.
  - The sdata bit sampled at that rise belongs to channel lr_d (its old value), giving the standard I2S one-bit delay.
REQ-016 A channel start is a rise at which lr_d != lr_dd; this resets the 5-bit saturating bit counter to 0 before the bit is counted.
REQ-017 Only the first 16 bits of a channel shift MSB-first into that channel's 16-bit register; further bits up to the next channel start are ignored.
REQ-018 State machine: SYNC, LEFT, RIGHT.
  - SYNC -> LEFT on a channel start with lr_d = 0.
  - LEFT -> RIGHT and RIGHT -> LEFT on each channel start.
  - Bits received in SYNC are discarded.
REQ-019 Completion of the 16th bit in LEFT sets left_ok; left_ok clears at every LEFT entry.
REQ-020 At the 16th RIGHT bit, if left_ok = 1, push {left, right} into the FIFO.
  - The push occurs at the clk edge ending the detection cycle.
  - aud_out_rts is high from the next cycle.
REQ-021 If a channel start occurs with the bit counter < 16 in the channel being left, frame_err pulses and that frame is not pushed.
REQ-022 A handshake transfer occurs in any cycle where aud_out_rts = 1 and aud_out_rtr = 1; the FIFO pops at that edge.
REQ-023 aud_out shall hold the head frame stable while aud_out_rts = 1 and no transfer occurs; aud_out_rts never deasserts without a transfer.
REQ-024 Push when full with no pop: the new frame is dropped, overflow pulses, and FIFO contents are unchanged.
REQ-025 Push and pop in the same cycle: both take effect, fifo_level is unchanged, and this holds even when full.
REQ-026 Pop when empty is impossible, because aud_out_rts = 0.
REQ-027 FIFO read and write pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
REQ-028 When empty, aud_out is don't-care.

Reset
REQ-029 While rst = 1 the block shall be held in reset:
  - state = SYNC; pointers and fifo_level = 0.
  - aud_out_rts = 0, overflow = 0, frame_err = 0.
  - Channel registers, bit counter, left_ok, lr_d and lr_dd = 0.
  - Synchronizer flops = 0.
REQ-030 Reset asserted mid-frame or mid-handshake shall discard all buffered and partial frames.
  - After release, no frame is pushed until a SYNC -> LEFT transition has occurred.

Verification
REQ-031 Single frame: send L=0xA5C3, R=0x1234 with 16 bclk per channel, rtr=1 -> one transfer with aud_out=0xA5C31234, rts high for exactly 1 cycle.
REQ-032 Backpressure: rtr=0, send 5 frames (0x00010002..0x00090010 pattern).
  - Expected: fifo_level reaches 4; overflow pulses once on the 5th frame.
  - Then rtr=1: exactly the first 4 frames are transferred, in order, and aud_out is stable while rtr=0.
REQ-033 32 bclk per channel: L=0xBEEF, then 16 ignored bits, R=0xCAFE -> aud_out=0xBEEFCAFE.
REQ-034 Short channel: a left channel of 12 bits -> frame_err pulses once, no push; the next well-formed frame is transferred normally.
REQ-035 Reset mid-frame:
  - Assert rst after 8 left bits, release, resume mid-right channel.
  - Expected: no push for that frame; the first full frame after a left start is delivered.
REQ-036 Full with simultaneous pop: with FIFO full and rtr=1 in the push cycle -> no overflow, fifo_level stays 4.

Source files
------------

// File: rtl/i2s_rx_stream.sv
// I2S receiver: synchronizes the serial bus into clk, assembles 16-bit left/right
// words into 32-bit frames and hands them to a ready/ready stream through a small FIFO.
module i2s_rx_stream #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i2s_bclk,
   input  logic                     i2s_lrclk,
   input  logic                     i2s_sdata,
   output logic [31:0]              aud_out,
   output logic                     aud_out_rts,
   input  logic                     aud_out_rtr,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     frame_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

   state_e r_state;
   state_e w_state_next;

   logic r_bclk_s1, r_bclk_s2, r_bclk_q;
   logic r_lr_s1, r_lr_s2;
   logic r_sd_s1, r_sd_s2;
   logic r_lr_d, r_lr_dd;
   logic [4:0]  r_cnt;
   logic [15:0] r_left, r_right;
   logic r_left_ok;
   logic r_overflow, r_frame_err;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_level;

   logic        w_rise;
   logic        w_start;
   logic [4:0]  w_cnt_eff;
   logic [4:0]  w_cnt_next;
   logic        w_take;
   logic        w_last;
   logic        w_frame_err;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_write;
   logic [15:0] w_shift_left;
   logic [15:0] w_shift_right;

   assign w_rise        = r_bclk_s2 & ~r_bclk_q;
   assign w_shift_left  = {r_left[14:0], r_sd_s2};
   assign w_shift_right = {r_right[14:0], r_sd_s2};

   // The bit sampled at a rise belongs to channel r_lr_d, so channel boundaries are judged
   // on the pre-update lr_d/lr_dd pair.
   always_comb begin
      w_state_next = r_state;
      w_start      = w_rise && (r_lr_d != r_lr_dd);
      if (w_start) begin
         unique case (r_state)
            StSync:  if (!r_lr_d) w_state_next = StLeft;
            StLeft:  w_state_next = StRight;
            StRight: w_state_next = StLeft;
            default: w_state_next = StSync;
         endcase
      end
      w_cnt_eff   = w_start ? 5'd0 : r_cnt;
      w_cnt_next  = (w_cnt_eff == 5'd31) ? w_cnt_eff : w_cnt_eff + 5'd1;
      w_take      = w_rise && (w_state_next != StSync) && (w_cnt_eff < 5'd16);
      w_last      = w_take && (w_cnt_eff == 5'd15);
      w_frame_err = w_start && (r_state != StSync) && (r_cnt < 5'd16);
      w_push      = w_last && (w_state_next == StRight) && r_left_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StSync;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bclk_s1 <= 1'b0;
         r_bclk_s2 <= 1'b0;
         r_bclk_q  <= 1'b0;
         r_lr_s1   <= 1'b0;
         r_lr_s2   <= 1'b0;
         r_sd_s1   <= 1'b0;
         r_sd_s2   <= 1'b0;
      end else begin
         r_bclk_s1 <= i2s_bclk;
         r_bclk_s2 <= r_bclk_s1;
         r_bclk_q  <= r_bclk_s2;
         r_lr_s1   <= i2s_lrclk;
         r_lr_s2   <= r_lr_s1;
         r_sd_s1   <= i2s_sdata;
         r_sd_s2   <= r_sd_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lr_d      <= 1'b0;
         r_lr_dd     <= 1'b0;
         r_cnt       <= 5'd0;
         r_left      <= 16'd0;
         r_right     <= 16'd0;
         r_left_ok   <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_rise) begin
            r_lr_d  <= r_lr_s2;
            r_lr_dd <= r_lr_d;
            r_cnt   <= w_cnt_next;
            if (w_take && (w_state_next == StLeft)) begin
               r_left <= w_shift_left;
            end
            if (w_take && (w_state_next == StRight)) begin
               r_right <= w_shift_right;
            end
            if (w_start && (w_state_next == StLeft)) begin
               r_left_ok <= 1'b0;
            end else if (w_last && (w_state_next == StLeft)) begin
               r_left_ok <= 1'b1;
            end
         end
         r_overflow  <= w_push && w_full && !w_pop;
         r_frame_err <= w_frame_err;
      end
   end

   assign w_full  = (r_level == LvlFull);
   assign w_pop   = aud_out_rts && aud_out_rtr;
   // A full FIFO still accepts a frame when the head leaves in the same cycle.
   assign w_write = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wptr] <= {r_left, w_shift_right};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_write) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_write, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign aud_out     = r_mem[r_rptr];
   assign aud_out_rts = (r_level != '0);
   assign fifo_level  = r_level;
   assign overflow    = r_overflow;
   assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Bench for i2s_rx_stream: drives an I2S slot stream and compares the output stream
// against a frame-level queue model of the expected deliveries.
module tb_i2s_rx_stream;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        bclk, lrclk, sdata, rtr;
   logic [31:0] aud_out;
   logic        rts;
   logic [2:0]  level;
   logic        ovf, ferr;

   int n_checks = 0;
   int n_fail   = 0;
   int xfers = 0, rts_cycles = 0, ovf_seen = 0, ferr_seen = 0;
   int ovf_exp = 0, ferr_exp = 0;
   logic [31:0] exp_q[$];
   bit          stall = 1'b0;
   logic [31:0] held;
   bit          have_pend = 1'b0;
   logic        pend_sd;
   int          x0, c0, o0;

   always #5 clk = ~clk;

   i2s_rx_stream #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .i2s_bclk   (bclk),
      .i2s_lrclk  (lrclk),
      .i2s_sdata  (sdata),
      .aud_out    (aud_out),
      .aud_out_rts(rts),
      .aud_out_rtr(rtr),
      .fifo_level (level),
      .overflow   (ovf),
      .frame_err  (ferr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bclk period of 10 clk; with pulse set, rtr is raised only for the cycle that
   // ends with this slot's rise being acted on (two sync flops, then one detection cycle).
   task automatic emit_slot(input logic lr, input logic sd, input bit pulse);
      bclk  = 1'b0;
      lrclk = lr;
      sdata = sd;
      repeat (5) tick();
      bclk = 1'b1;
      if (pulse) begin
         repeat (2) tick();
         rtr = 1'b1;
         tick();
         rtr = 1'b0;
         repeat (2) tick();
      end else begin
         repeat (5) tick();
      end
   endtask

   // lrclk leads data by one slot, so a slot goes out once the next slot's channel is known.
   task automatic push_slot(input logic chan, input logic sd);
      if (have_pend) emit_slot(chan, pend_sd, 1'b0);
      pend_sd   = sd;
      have_pend = 1'b1;
   endtask

   task automatic flush(input logic next_chan, input bit pulse);
      if (have_pend) emit_slot(next_chan, pend_sd, pulse);
      have_pend = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                             input int nr, input bit pulse);
      if (nl < 16) ferr_exp++;
      if (nr < 16) ferr_exp++;
      if (nl >= 16 && nr >= 16) begin
         if (!rtr && !pulse && exp_q.size() >= DEPTH) ovf_exp++;
         else exp_q.push_back({l, r});
      end
      for (int i = 0; i < nl; i++) push_slot(1'b0, (i < 16) ? l[15-i] : 1'($urandom_range(0, 1)));
      for (int i = 0; i < nr; i++) push_slot(1'b1, (i < 16) ? r[15-i] : 1'($urandom_range(0, 1)));
      flush(1'b0, pulse);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("hold_rts", 32'(rts), 32'd1);
            chk("hold_data", aud_out, held);
         end
         if (rts && rtr) begin
            xfers++;
            chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               chk("xfer_data", aud_out, exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
         stall = rts && !rtr;
         held  = aud_out;
         if (rts)  rts_cycles++;
         if (ovf)  ovf_seen++;
         if (ferr) ferr_seen++;
      end
   end

   logic [15:0] bp_l [5] = '{16'h0001, 16'h0003, 16'h0005, 16'h0007, 16'h0009};
   logic [15:0] bp_r [5] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0010};

   initial begin
      rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; rtr = 1'b0;
      repeat (4) tick();
      chk("rst_rts", 32'(rts), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_ferr", 32'(ferr), 32'd0);
      rst = 1'b0;
      tick();

      // Single frame; a short right-channel preamble gives the first left start.
      rtr = 1'b1;
      repeat (4) push_slot(1'b1, 1'b0);
      x0 = xfers; c0 = rts_cycles;
      send_frame(16'hA5C3, 16'h1234, 16, 16, 1'b0);
      repeat (10) tick();
      chk("single_xfers", 32'(xfers - x0), 32'd1);
      chk("single_rts_cycles", 32'(rts_cycles - c0), 32'd1);
      chk("single_level", 32'(level), 32'd0);

      // 32-bit slots: only the first 16 bits of each channel count.
      x0 = xfers;
      send_frame(16'hBEEF, 16'hCAFE, 32, 32, 1'b0);
      repeat (10) tick();
      chk("long_xfers", 32'(xfers - x0), 32'd1);

      // Short left channel, then a good frame.
      x0 = xfers;
      send_frame(16'($urandom), 16'($urandom), 12, 16, 1'b0);
      send_frame(16'($urandom), 16'($urandom), 16, 16, 1'b0);
      repeat (10) tick();
      chk("short_ferr", 32'(ferr_seen), 32'(ferr_exp));
      chk("short_xfers", 32'(xfers - x0), 32'd1);

      // Backpressure: five frames into a four-deep FIFO.
      rtr = 1'b0;
      x0 = xfers; o0 = ovf_seen;
      for (int k = 0; k < 5; k++) send_frame(bp_l[k], bp_r[k], 16, 16, 1'b0);
      repeat (10) tick();
      chk("bp_level", 32'(level), 32'(DEPTH));
      chk("bp_ovf_once", 32'(ovf_seen - o0), 32'd1);
      chk("bp_no_xfer", 32'(xfers - x0), 32'd0);
      rtr = 1'b1;
      repeat (10) tick();
      chk("bp_drain_xfers", 32'(xfers - x0), 32'd4);
      chk("bp_drain_level", 32'(level), 32'd0);

      // Full FIFO with a pop in the very push cycle.
      rtr = 1'b0;
      x0 = xfers; o0 = ovf_seen;
      for (int k = 0; k < 4; k++) send_frame(16'($urandom), 16'($urandom), 16, 16, 1'b0);
      send_frame(16'h5A5A, 16'hC0DE, 16, 16, 1'b1);
      repeat (3) tick();
      chk("fullpop_level", 32'(level), 32'(DEPTH));
      chk("fullpop_no_ovf", 32'(ovf_seen - o0), 32'd0);
      rtr = 1'b1;
      repeat (10) tick();
      chk("fullpop_xfers", 32'(xfers - x0), 32'd5);

      // Reset with frames buffered and a left channel half received.
      rtr = 1'b0;
      send_frame(16'($urandom), 16'($urandom), 16, 16, 1'b0);
      send_frame(16'($urandom), 16'($urandom), 16, 16, 1'b0);
      for (int i = 0; i < 8; i++) push_slot(1'b0, 1'($urandom_range(0, 1)));
      flush(1'b0, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      repeat (3) tick();
      chk("midrst_level_held", 32'(level), 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_rts", 32'(rts), 32'd0);
      for (int i = 0; i < 8; i++) push_slot(1'b1, 1'($urandom_range(0, 1)));
      flush(1'b0, 1'b0);
      repeat (10) tick();
      chk("midrst_no_push", 32'(level), 32'd0);
      rtr = 1'b1;
      x0 = xfers;
      send_frame(16'($urandom), 16'($urandom), 16, 16, 1'b0);
      repeat (10) tick();
      chk("midrst_next_xfer", 32'(xfers - x0), 32'd1);

      // Random frames, random slot lengths and random consumer readiness.
      for (int k = 0; k < 8; k++) begin
         rtr = 1'($urandom_range(0, 1));
         repeat (8) tick();
         send_frame(16'($urandom), 16'($urandom), 16 + int'($urandom_range(0, 4)),
                    16 + int'($urandom_range(0, 4)), 1'b0);
      end
      rtr = 1'b1;
      repeat (10) tick();

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("final_level", 32'(level), 32'd0);
      chk("final_ovf", 32'(ovf_seen), 32'(ovf_exp));
      chk("final_ferr", 32'(ferr_seen), 32'(ferr_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
